fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 138 +++++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, a 1-entry skid buffer for
// responses that arrive while decode is stalled, and redirect/flush handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        pc_sel_i,
  input  logic [31:0] pc_target_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        inst_valid_o,
  output logic        misalign_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] ifid_pc_q;
  logic        valid_q;
  logic        misalign_q;
  logic [31:0] skid_q;

  logic [31:0] redirect_pc_d;
  logic [31:0] pc_inc_d;
  logic        skid_load_d;

  assign redirect_pc_d = {pc_target_i[31:2], 2'b00};
  assign pc_inc_d      = pc_q + 32'd4;
  assign skid_load_d   = (state_q == S_WAIT) && imem_rvalid_i && stall_i && !pc_sel_i;

  // Gated by rst so no request is visible while reset is held, yet the request
  // appears in the very first cycle after release.
  assign imem_req_o   = (state_q == S_REQ) && !rst;
  assign imem_addr_o  = pc_q;
  assign inst_o       = inst_q;
  assign pc_o         = ifid_pc_q;
  assign inst_valid_o = valid_q;
  assign misalign_o   = misalign_q;

  // NOTE: the skid data register has no reset; its contents only matter in S_HOLD,
  // which is entered solely by writing it, so reset occupancy lives in state_q.
  always_ff @(posedge clk) begin
    if (skid_load_d) begin
      skid_q <= imem_rdata_i;
    end
  end

  // NOTE: every register below is assigned with <= so all of them sample the
  // pre-edge values of each other, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      inst_q     <= NOP_INST;
      ifid_pc_q  <= RESET_PC;
      valid_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= pc_sel_i && (pc_target_i[1:0] != 2'b00);
      if (pc_sel_i) begin
        // Redirect wins over stall and any response; an in-flight request is drained in S_DROP.
        pc_q    <= redirect_pc_d;
        inst_q  <= NOP_INST;
        valid_q <= 1'b0;
        unique case (state_q)
          S_REQ:   state_q <= imem_gnt_i    ? S_DROP : S_REQ;
          S_WAIT:  state_q <= imem_rvalid_i ? S_REQ  : S_DROP;
          S_HOLD:  state_q <= S_REQ;
          S_DROP:  state_q <= imem_rvalid_i ? S_REQ  : S_DROP;
          default: state_q <= S_REQ;
        endcase
      end else begin
        unique case (state_q)
          S_REQ: begin
            if (imem_gnt_i) begin
              state_q <= S_WAIT;
            end
            if (!stall_i) begin
              inst_q  <= NOP_INST;
              valid_q <= 1'b0;
            end
          end
          S_WAIT: begin
            if (imem_rvalid_i) begin
              if (stall_i) begin
                state_q <= S_HOLD;
              end else begin
                inst_q    <= imem_rdata_i;
                ifid_pc_q <= pc_q;
                valid_q   <= 1'b1;
                pc_q      <= pc_inc_d;
                state_q   <= S_REQ;
              end
            end else if (!stall_i) begin
              inst_q  <= NOP_INST;
              valid_q <= 1'b0;
            end
          end
          S_HOLD: begin
            if (!stall_i) begin
              inst_q    <= skid_q;
              ifid_pc_q <= pc_q;
              valid_q   <= 1'b1;
              pc_q      <= pc_inc_d;
              state_q   <= S_REQ;
            end
          end
          S_DROP: begin
            if (imem_rvalid_i) begin
              state_q <= S_REQ;
            end
            if (!stall_i) begin
              inst_q  <= NOP_INST;
              valid_q <= 1'b0;
            end
          end
          default: state_q <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a directed cycle table for the documented corner cases, then
// random traffic from a memory model checked against a transaction-level reference.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        stall;
  logic        sel;
  logic [31:0] tgt;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        valid;
  logic        mis;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req_o   (imem_req),
    .imem_addr_o  (imem_addr),
    .imem_gnt_i   (gnt),
    .imem_rvalid_i(rvalid),
    .imem_rdata_i (rdata),
    .stall_i      (stall),
    .pc_sel_i     (sel),
    .pc_target_i  (tgt),
    .inst_o       (inst),
    .pc_o         (pc),
    .inst_valid_o (valid),
    .misalign_o   (mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Directed vectors: inputs applied for one cycle; req/addr expected during that
  // cycle, IF/ID and misalign expected after the following rising edge.
  typedef struct {
    logic        rst, gnt, rv;
    logic [31:0] rdata;
    logic        stall, sel;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr, exp_inst, exp_pc;
    logic        exp_valid, exp_mis, chk_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, g, v, input logic [31:0] d, input logic s, p,
                     input logic [31:0] t, input logic eq, input logic [31:0] ea, ei, ep,
                     input logic ev, em);
    vec_t x;
    x.rst = r; x.gnt = g; x.rv = v; x.rdata = d; x.stall = s; x.sel = p; x.tgt = t;
    x.exp_req = eq; x.exp_addr = ea; x.exp_inst = ei; x.exp_pc = ep;
    x.exp_valid = ev; x.exp_mis = em; x.chk_pc = ev | r;
    vecs.push_back(x);
  endtask

  // Reference model state: what the fetch stage owes the memory and decode.
  logic [31:0] m_pc, m_inst, m_pc_o, m_park;
  logic        m_busy, m_stale, m_parked, m_valid, m_mis;

  task automatic model_reset();
    m_pc = 32'h0; m_inst = NOP; m_pc_o = 32'h0; m_park = 32'h0;
    m_busy = 1'b0; m_stale = 1'b0; m_parked = 1'b0; m_valid = 1'b0; m_mis = 1'b0;
  endtask

  task automatic model_deliver(input logic [31:0] d);
    m_inst = d; m_pc_o = m_pc; m_valid = 1'b1; m_pc = m_pc + 32'd4;
  endtask

  task automatic model_step(input logic g, v, input logic [31:0] d, input logic s, p,
                            input logic [31:0] t);
    logic req_now;
    logic outstanding;
    req_now = !m_busy && !m_parked;
    m_mis = p && (t[1:0] != 2'b00);
    if (p) begin
      outstanding = (req_now && g) || (m_busy && !v);
      m_busy = outstanding; m_stale = outstanding; m_parked = 1'b0;
      m_valid = 1'b0; m_inst = NOP; m_pc = {t[31:2], 2'b00};
    end else if (req_now) begin
      if (g) begin m_busy = 1'b1; m_stale = 1'b0; end
      if (!s) begin m_valid = 1'b0; m_inst = NOP; end
    end else if (m_busy) begin
      if (v && !m_stale && !s) begin
        m_busy = 1'b0; model_deliver(d);
      end else if (v && !m_stale) begin
        m_busy = 1'b0; m_parked = 1'b1; m_park = d;
      end else begin
        if (v) m_busy = 1'b0;
        if (!s) begin m_valid = 1'b0; m_inst = NOP; end
      end
    end else if (!s) begin
      m_parked = 1'b0; model_deliver(m_park);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0F0F_1357;
  endfunction

  initial begin
    bit          pend;
    int          cnt;
    logic [31:0] paddr;

    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0; stall = 1'b0; sel = 1'b0; tgt = '0;

    //   rst g rv rdata          st sel tgt           req addr           inst           pc             v  mis
    add(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h0,         NOP,           32'h0,         0, 0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         NOP,           32'h0,         0, 0);
    add(0, 0, 1, 32'h00F0016F,  0, 0, 32'h0,         0, 32'h0,         32'h00F0016F,  32'h0,         1, 0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h4,         NOP,           32'h0,         0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h4,         NOP,           32'h0,         0, 0);
    add(0, 0, 1, 32'h00000093,  0, 0, 32'h0,         0, 32'h4,         32'h00000093,  32'h4,         1, 0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h8,         NOP,           32'h0,         0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h8,         NOP,           32'h0,         0, 0);
    add(0, 0, 1, 32'h00100113,  0, 0, 32'h0,         0, 32'h8,         32'h00100113,  32'h8,         1, 0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'hC,         NOP,           32'h0,         0, 0);
    add(0, 0, 1, 32'h00310233,  1, 0, 32'h0,         0, 32'hC,         NOP,           32'h0,         0, 0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         0, 32'hC,         NOP,           32'h0,         0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'hC,         32'h00310233,  32'hC,         1, 0);
    add(0, 0, 0, 32'h0,         1, 0, 32'h0,         1, 32'h10,        32'h00310233,  32'hC,         1, 0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h10,        NOP,           32'h0,         0, 0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h40,        0, 32'h10,        NOP,           32'h0,         0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h40,        NOP,           32'h0,         0, 0);
    add(0, 0, 1, 32'hDEADBEEF,  0, 0, 32'h0,         0, 32'h40,        NOP,           32'h0,         0, 0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h40,        NOP,           32'h0,         0, 0);
    add(0, 0, 1, 32'h00000513,  0, 0, 32'h0,         0, 32'h40,        32'h00000513,  32'h40,        1, 0);
    add(0, 0, 0, 32'h0,         0, 1, 32'h42,        1, 32'h44,        NOP,           32'h0,         0, 1);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h40,        NOP,           32'h0,         0, 0);
    add(0, 0, 0, 32'h0,         0, 1, 32'hFFFFFFFC,  1, 32'h40,        NOP,           32'h0,         0, 0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'hFFFFFFFC,  NOP,           32'h0,         0, 0);
    add(0, 0, 1, 32'h00A00093,  0, 0, 32'h0,         0, 32'hFFFFFFFC,  32'h00A00093,  32'hFFFFFFFC,  1, 0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         NOP,           32'h0,         0, 0);
    add(0, 0, 1, 32'h11111111,  0, 1, 32'h80,        0, 32'h0,         NOP,           32'h0,         0, 0);
    add(0, 0, 0, 32'h0,         0, 0, 32'h0,         1, 32'h80,        NOP,           32'h0,         0, 0);
    add(0, 1, 0, 32'h0,         0, 1, 32'h100,       1, 32'h80,        NOP,           32'h0,         0, 0);
    add(0, 0, 1, 32'h22222222,  0, 0, 32'h0,         0, 32'h100,       NOP,           32'h0,         0, 0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h100,       NOP,           32'h0,         0, 0);
    add(0, 0, 1, 32'h44444444,  1, 0, 32'h0,         0, 32'h100,       NOP,           32'h0,         0, 0);
    add(0, 0, 0, 32'h0,         1, 1, 32'h201,       0, 32'h100,       NOP,           32'h0,         0, 1);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h200,       NOP,           32'h0,         0, 0);
    add(1, 0, 0, 32'h0,         0, 0, 32'h0,         0, 32'h200,       NOP,           32'h0,         0, 0);
    add(0, 0, 1, 32'h33333333,  0, 0, 32'h0,         1, 32'h0,         NOP,           32'h0,         0, 0);
    add(0, 1, 0, 32'h0,         0, 0, 32'h0,         1, 32'h0,         NOP,           32'h0,         0, 0);
    add(0, 0, 1, 32'h12345678,  0, 0, 32'h0,         0, 32'h0,         32'h12345678,  32'h0,         1, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; gnt = vecs[i].gnt; rvalid = vecs[i].rv; rdata = vecs[i].rdata;
      stall = vecs[i].stall; sel = vecs[i].sel; tgt = vecs[i].tgt;
      #1;
      check($sformatf("v%0d req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      check($sformatf("v%0d addr", i), imem_addr, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      check($sformatf("v%0d inst", i), inst, vecs[i].exp_inst);
      check($sformatf("v%0d valid", i), {31'b0, valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("v%0d misalign", i), {31'b0, mis}, {31'b0, vecs[i].exp_mis});
      if (vecs[i].chk_pc) check($sformatf("v%0d pc", i), pc, vecs[i].exp_pc);
    end

    // Random traffic: memory grants at random and answers 1-3 cycles after grant.
    @(negedge clk);
    rst = 1'b1; gnt = 1'b0; rvalid = 1'b0; stall = 1'b0; sel = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    pend = 1'b0; cnt = 0; paddr = '0;

    for (int c = 0; c < 3000; c++) begin
      check("rnd inst", inst, m_inst);
      check("rnd valid", {31'b0, valid}, {31'b0, m_valid});
      check("rnd misalign", {31'b0, mis}, {31'b0, m_mis});
      if (m_valid) check("rnd pc", pc, m_pc_o);

      rvalid = 1'b0; rdata = $urandom;
      if (pend && cnt == 0) begin
        rvalid = 1'b1; rdata = mem_word(paddr); pend = 1'b0;
      end else if (pend) begin
        cnt--;
      end
      gnt   = ($urandom_range(0, 2) != 0);
      stall = ($urandom_range(0, 2) == 0);
      sel   = ($urandom_range(0, 11) == 0);
      tgt   = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) tgt = 32'hFFFF_FFFC;
      if (gnt && !m_busy && !m_parked) begin
        pend = 1'b1; paddr = m_pc; cnt = $urandom_range(0, 2);
      end
      #1;
      check("rnd req", {31'b0, imem_req}, {31'b0, !m_busy && !m_parked});
      check("rnd addr", imem_addr, m_pc);
      model_step(gnt, rvalid, rdata, stall, sel, tgt);
      @(posedge clk);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
